// File: rtl/cic_comp_pkg.sv
// Shared state type and width helpers for the CIC compensation FIR.
package cic_comp_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_MAC,
        ST_DRAIN,
        ST_ROUND
    } fsm_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Headroom for TAPS full-scale products summed without wrapping.
    function automatic int acc_width(input int inp_dw, input int coef_dw,
                                     input int taps);
        return inp_dw + coef_dw + clog2(taps);
    endfunction

    function automatic int coef_lsb(input int tap, input int coef_dw);
        return tap * coef_dw;
    endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Registered multiplier, accumulator and round/saturate output stage.
module cic_comp_mac
    import cic_comp_pkg::*;
#(
    parameter int INP_DW    = 32,
    parameter int OUT_DW    = 32,
    parameter int COEF_DW   = 18,
    parameter int TAPS      = 31,
    parameter int COEF_FRAC = 17,
    parameter logic [COEF_DW*TAPS-1:0] COEF = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      mul_en,
    input  logic                      last,
    input  logic signed [INP_DW-1:0]  sample,
    input  logic [clog2(TAPS)-1:0]    tap,
    output logic signed [OUT_DW-1:0]  out_data,
    output logic                      done,
    output logic                      sat_flag
);

    localparam int ACC_DW = acc_width(INP_DW, COEF_DW, TAPS);
    localparam int PRD_DW = INP_DW + COEF_DW;
    localparam int RND_DW = ACC_DW + 1;
    localparam int EXT_DW = (RND_DW > OUT_DW) ? RND_DW : OUT_DW;
    localparam int RND_SH = (COEF_FRAC > 0) ? COEF_FRAC - 1 : 0;

    localparam logic signed [EXT_DW-1:0] RND_BIAS =
        (COEF_FRAC > 0) ? (EXT_DW'(1) <<< RND_SH) : '0;
    localparam logic signed [EXT_DW-1:0] OUT_MAX =
        (EXT_DW'(1) <<< (OUT_DW - 1)) - EXT_DW'(1);
    localparam logic signed [EXT_DW-1:0] OUT_MIN = -OUT_MAX - EXT_DW'(1);

    logic signed [COEF_DW-1:0] coef_tab [TAPS];
    logic signed [PRD_DW-1:0]  prod;
    logic                      prod_vld;
    logic signed [ACC_DW-1:0]  acc;
    logic signed [EXT_DW-1:0]  rnd_sum;
    logic signed [EXT_DW-1:0]  rnd_shr;
    logic signed [OUT_DW-1:0]  clip_out;
    logic                      clip_hit;

    for (genvar i = 0; i < TAPS; i++) begin : g_coef
        assign coef_tab[i] = COEF[coef_lsb(i, COEF_DW) +: COEF_DW];
    end

    always_comb begin
        rnd_sum  = EXT_DW'(acc) + RND_BIAS;
        rnd_shr  = rnd_sum >>> COEF_FRAC;
        clip_out = rnd_shr[OUT_DW-1:0];
        clip_hit = 1'b0;
        if (rnd_shr > OUT_MAX) begin
            clip_out = OUT_MAX[OUT_DW-1:0];
            clip_hit = 1'b1;
        end else if (rnd_shr < OUT_MIN) begin
            clip_out = OUT_MIN[OUT_DW-1:0];
            clip_hit = 1'b1;
        end
    end

    // Product lands one cycle after its tap is read; prod_vld tracks that.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
            out_data <= '0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            prod_vld <= mul_en;
            done     <= last;
            if (mul_en) begin
                prod <= PRD_DW'(sample) * PRD_DW'(coef_tab[tap]);
            end
            if (start) begin
                acc <= '0;
            end else if (prod_vld) begin
                acc <= acc + ACC_DW'(prod);
            end
            if (last) begin
                out_data <= clip_out;
                if (clip_hit) sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR: ring buffer, phase counter and control FSM.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int INP_DW    = 32,
    parameter int OUT_DW    = 32,
    parameter int COEF_DW   = 18,
    parameter int TAPS      = 31,
    parameter int COEF_FRAC = 17,
    parameter int DEC       = 1,
    parameter logic [COEF_DW*TAPS-1:0] COEF = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [INP_DW-1:0] s_axis_in_tdata,
    input  logic                     s_axis_in_tvalid,
    output logic signed [OUT_DW-1:0] m_axis_out_tdata,
    output logic                     m_axis_out_tvalid,
    output logic                     sat_flag,
    output logic                     drop_flag
);

    localparam int AW = clog2(TAPS);
    localparam int PW = (DEC > 1) ? clog2(DEC) : 1;
    localparam logic [AW-1:0] TAP_LAST = AW'(TAPS - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(DEC - 1);

    fsm_t state, state_nx;

    logic [AW-1:0] cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] buf_addr;
    logic [PW-1:0] phase;

    logic signed [INP_DW-1:0] ring [TAPS];
    logic signed [INP_DW-1:0] buf_wdata;

    logic buf_we;
    logic accept;
    logic drop;
    logic mac_start;
    logic mac_mul;
    logic mac_last;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_CLEAR;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        buf_we    = 1'b0;
        buf_addr  = wr_ptr;
        buf_wdata = s_axis_in_tdata;
        accept    = 1'b0;
        drop      = 1'b0;
        mac_start = 1'b0;
        mac_mul   = 1'b0;
        mac_last  = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                buf_we    = 1'b1;
                buf_addr  = cnt;
                buf_wdata = '0;
                drop      = s_axis_in_tvalid;
                if (cnt == TAP_LAST) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (s_axis_in_tvalid) begin
                    buf_we = 1'b1;
                    accept = 1'b1;
                    if (phase == PH_LAST) begin
                        mac_start = 1'b1;
                        state_nx  = ST_MAC;
                    end
                end
            end
            ST_MAC: begin
                mac_mul = 1'b1;
                drop    = s_axis_in_tvalid;
                if (cnt == TAP_LAST) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                drop     = s_axis_in_tvalid;
                state_nx = ST_ROUND;
            end
            ST_ROUND: begin
                drop     = s_axis_in_tvalid;
                mac_last = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n && buf_we) ring[buf_addr] <= buf_wdata;
    end

    // rd_ptr starts on the newest sample and walks backwards through history.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            phase     <= '0;
            drop_flag <= 1'b0;
        end else begin
            if (drop) drop_flag <= 1'b1;
            if (state == ST_CLEAR || state == ST_MAC) begin
                cnt <= (cnt == TAP_LAST) ? '0 : cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (accept) begin
                wr_ptr <= (wr_ptr == TAP_LAST) ? '0 : wr_ptr + 1'b1;
                rd_ptr <= wr_ptr;
                phase  <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            end else if (state == ST_MAC) begin
                rd_ptr <= (rd_ptr == '0) ? TAP_LAST : rd_ptr - 1'b1;
            end
        end
    end

    cic_comp_mac #(
        .INP_DW   (INP_DW),
        .OUT_DW   (OUT_DW),
        .COEF_DW  (COEF_DW),
        .TAPS     (TAPS),
        .COEF_FRAC(COEF_FRAC),
        .COEF     (COEF)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mac_start),
        .mul_en  (mac_mul),
        .last    (mac_last),
        .sample  (ring[rd_ptr]),
        .tap     (cnt),
        .out_data(m_axis_out_tdata),
        .done    (m_axis_out_tvalid),
        .sat_flag(sat_flag)
    );

endmodule

// File: tb/tb_cic_comp_fir.sv
// Randomized bench for cic_comp_fir against a sample-history reference model.
module tb_cic_comp_fir;

    localparam int INP_DW    = 16;
    localparam int OUT_DW    = 16;
    localparam int COEF_DW   = 10;
    localparam int TAPS      = 5;
    localparam int COEF_FRAC = 3;
    localparam int DEC       = 2;
    localparam logic [COEF_DW*TAPS-1:0] COEF =
        {10'h3F9, 10'h002, 10'h008, 10'h3FD, 10'h005};
    localparam int  BUSY = TAPS + 2;
    localparam longint OMAX = 32767;
    localparam longint OMIN = -32768;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     tvalid = 1'b0;
    logic signed [INP_DW-1:0] tdata = '0;
    logic signed [OUT_DW-1:0] out_data;
    logic                     out_valid;
    logic                     sat_flag;
    logic                     drop_flag;

    int     cf [TAPS] = '{5, -3, 8, 2, -7};
    longint hist [TAPS];
    int     phase, clear_left, busy_left;
    bit     exp_valid, exp_sat, exp_drop, pend_sat, armed;
    longint exp_data, pend_data;
    int     checks, errors;

    always #5 clk = ~clk;

    cic_comp_fir #(
        .INP_DW   (INP_DW),
        .OUT_DW   (OUT_DW),
        .COEF_DW  (COEF_DW),
        .TAPS     (TAPS),
        .COEF_FRAC(COEF_FRAC),
        .DEC      (DEC),
        .COEF     (COEF)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s_axis_in_tdata  (tdata),
        .s_axis_in_tvalid (tvalid),
        .m_axis_out_tdata (out_data),
        .m_axis_out_tvalid(out_valid),
        .sat_flag         (sat_flag),
        .drop_flag        (drop_flag)
    );

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint rnd_shift(input longint acc);
        return (acc + (longint'(1) <<< (COEF_FRAC - 1))) >>> COEF_FRAC;
    endfunction

    // Sample-level view: history of accepted samples, busy/clear windows.
    task automatic model_edge(input bit rst, input bit v, input int d);
        longint acc, r;
        if (rst) begin
            clear_left = TAPS;
            busy_left  = 0;
            phase      = 0;
            for (int k = 0; k < TAPS; k++) hist[k] = 0;
            exp_valid = 0;
            exp_data  = 0;
            exp_sat   = 0;
            exp_drop  = 0;
        end else begin
            exp_valid = 0;
            if (clear_left > 0) begin
                exp_drop |= v;
                clear_left--;
            end else if (busy_left > 0) begin
                exp_drop |= v;
                busy_left--;
                if (busy_left == 0) begin
                    exp_valid = 1;
                    exp_data  = pend_data;
                    exp_sat  |= pend_sat;
                end
            end else if (v) begin
                for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = d;
                if (phase == DEC - 1) begin
                    phase = 0;
                    acc = 0;
                    for (int k = 0; k < TAPS; k++) acc += hist[k] * cf[k];
                    r = rnd_shift(acc);
                    pend_sat  = (r > OMAX) || (r < OMIN);
                    pend_data = (r > OMAX) ? OMAX : (r < OMIN) ? OMIN : r;
                    busy_left = BUSY;
                end else begin
                    phase++;
                end
            end
        end
    endtask

    task automatic drive(input bit rst, input bit v, input int d);
        @(negedge clk);
        reset_n = !rst;
        tvalid  = v;
        tdata   = d[INP_DW-1:0];
        model_edge(rst, v, d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0);
    endtask

    task automatic pair(input int a, input int b);
        drive(0, 1, a);
        drive(0, 1, b);
        idle(10);
    endtask

    always @(posedge clk) begin
        #1;
        if (armed) begin
            chk("tvalid", out_valid, exp_valid);
            chk("tdata", out_data, exp_data);
            chk("sat_flag", sat_flag, exp_sat);
            chk("drop_flag", drop_flag, exp_drop);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        armed  = 0;

        drive(1, 0, 0);
        armed = 1;
        drive(1, 0, 0);
        drive(0, 1, 77);
        idle(TAPS - 1);
        chk("clear_drop", drop_flag, 1);

        pair(8, 0);
        chk("lit_a", out_data, -3);
        chk("lit_a_model", exp_data, -3);
        pair(16, 16);
        chk("lit_b", out_data, 6);
        pair(-32768, 32767);
        chk("lit_satpos", out_data, 32767);
        chk("lit_satpos_flag", sat_flag, 1);
        pair(-32768, -32768);
        chk("lit_c", out_data, 16369);
        chk("lit_sat_sticky", sat_flag, 1);
        pair(32767, -32768);
        chk("lit_satneg", out_data, -32768);

        drive(1, 0, 0);
        idle(TAPS);
        chk("rst_drop", drop_flag, 0);
        chk("rst_sat", sat_flag, 0);
        drive(0, 1, 100);
        drive(0, 1, 100);
        idle(3);
        drive(0, 1, 5);
        idle(3);
        chk("ovr_drop", drop_flag, 1);
        drive(0, 1, 9);
        drive(0, 1, 11);
        idle(10);
        chk("lit_edge_accept", out_data, 129);

        drive(0, 1, 50);
        drive(0, 1, 60);
        idle(2);
        drive(1, 0, 0);
        drive(0, 1, 33);
        idle(TAPS - 1);
        idle(8);
        chk("midmac_out", out_data, 0);
        chk("midmac_drop", drop_flag, 1);
        pair(40, 7);
        chk("lit_after_clear", out_data, -11);

        for (int i = 0; i < 4000; i++) begin
            bit r, v;
            int d;
            r = ($urandom_range(0, 499) == 0);
            v = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) d = int'($signed(16'($urandom)));
            else d = int'($urandom_range(0, 200)) - 100;
            drive(r, v, d);
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
